// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions, FSM encodings, frame shape.
package uart_mmio_pkg;

   localparam logic [2:0] OFF_TXDATA = 3'h0;
   localparam logic [2:0] OFF_STATUS = 3'h4;

   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO with wrapping pointers and occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
      if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the count gates every read.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO.
// Window: TXDATA at +0 (write-only), STATUS at +4.
module uart_tx_mmio
   import uart_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic        i_we,
   output logic        o_sel,
   output logic [31:0] o_rdata,
   output logic        o_tx
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          ovf_q, ovf_d;

   logic [2:0]    off;
   logic          wr_data, wr_stat;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic [3:0]    status;
   logic          baud_last;
   logic          unused_w;

   assign o_sel   = (i_addr[31:3] == BASE_ADDR[31:3]);
   assign off     = {i_addr[2], 2'b00};
   assign wr_data = o_sel & i_we & (off == OFF_TXDATA);
   assign wr_stat = o_sel & i_we & (off == OFF_STATUS);

   assign status[ST_BUSY]  = (state_q != S_IDLE) | ~fifo_empty;
   assign status[ST_FULL]  = fifo_full;
   assign status[ST_EMPTY] = fifo_empty;
   assign status[ST_OVF]   = ovf_q;

   assign o_rdata = (o_sel && off == OFF_STATUS) ? {28'd0, status} : '0;
   assign o_tx    = tx_q;
   assign unused_w = ^{i_wdata[31:8], i_addr[1:0], fifo_count};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (i_clk),
      .rst_ni  (i_resetn),
      .push_i  (wr_data),
      .pop_i   (fifo_pop),
      .data_i  (i_wdata[7:0]),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Clear takes priority over a same-cycle drop.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_data && fifo_full)         ovf_d = 1'b1;
      if (wr_stat && i_wdata[ST_OVF])   ovf_d = 1'b0;
   end

   assign baud_last = (baud_q == BAUD_LAST);

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               baud_d   = '0;
               bit_d    = '0;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = S_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  bit_d    = '0;
                  state_d  = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Line level follows the next state so o_tx is a clean flop output.
   always_comb begin
      tx_d = 1'b1;
      if (state_d == S_START)     tx_d = 1'b0;
      else if (state_d == S_DATA) tx_d = shift_d[0];
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio against a frame-level line model.
// Random byte streams, overflow, mid-frame reset, unmapped stores.
module tb_uart_tx_mmio;

   localparam int C  = 4;
   localparam int D  = 8;
   localparam int FL = 10 * C;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        we = 1'b0;
   logic        sel;
   logic [31:0] rdata;
   logic        tx;

   int checks = 0;
   int errors = 0;

   logic [7:0] stim_q[$];

   always #5 clk = ~clk;

   uart_tx_mmio #(
      .BASE_ADDR    (32'h0000_1000),
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (D)
   ) dut (
      .i_clk    (clk),
      .i_resetn (rstn),
      .i_addr   (addr),
      .i_wdata  (wdata),
      .i_we     (we),
      .o_sel    (sel),
      .o_rdata  (rdata),
      .o_tx     (tx)
   );

   // Expected line level k cycles after the first frame begins,
   // for back-to-back 8N1 frames carrying stim_q in order.
   function automatic logic exp_line(int k);
      int f;
      int p;
      logic [7:0] b;
      f = k / FL;
      p = (k % FL) / C;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      b = stim_q[f];
      return b[p-1];
   endfunction

   task automatic test_reset();
      rstn = 1'b0;
      we   = 1'b0;
      addr = 32'h0000_1004;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx_in_reset got %b want 1", tx);
      end
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx got %b want 1", tx);
      end
      checks++;
      if (rdata !== 32'h4) begin
         errors++;
         $display("FAIL reset_status got %h want 4", rdata);
      end
      checks++;
      if (sel !== 1'b1) begin
         errors++;
         $display("FAIL sel_1004 got %b want 1", sel);
      end
      addr = 32'h0000_0FFC;
      #1;
      checks++;
      if (sel !== 1'b0) begin
         errors++;
         $display("FAIL sel_0ffc got %b want 0", sel);
      end
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("FAIL rdata_0ffc got %h want 0", rdata);
      end
      addr = 32'h0000_1000;
      #1;
      checks++;
      if (rdata !== 32'h0 || sel !== 1'b1) begin
         errors++;
         $display("FAIL txdata_read got sel=%b rdata=%h want sel=1 rdata=0",
                  sel, rdata);
      end
   endtask

   // Writes stim_q on consecutive cycles and checks the whole line trace.
   task automatic test_stream();
      int n;
      n = stim_q.size();
      fork
         begin
            for (int i = 0; i < n; i++) begin
               @(negedge clk);
               addr       = 32'h0000_1000;
               wdata      = $urandom();
               wdata[7:0] = stim_q[i];
               we         = 1'b1;
            end
            @(negedge clk);
            we   = 1'b0;
            addr = 32'h0000_1004;
         end
         begin
            repeat (2) @(negedge clk);
            for (int k = 0; k < FL * n; k++) begin
               @(negedge clk);
               checks++;
               if (tx !== exp_line(k)) begin
                  errors++;
                  $display("FAIL stream_tx k=%0d got %b want %b",
                           k, tx, exp_line(k));
               end
               if (k >= n) begin
                  checks++;
                  if (rdata[0] !== 1'b1) begin
                     errors++;
                     $display("FAIL stream_busy k=%0d got %b want 1",
                              k, rdata[0]);
                  end
               end
            end
         end
      join
      @(negedge clk);
      checks++;
      if (rdata !== 32'h4 || tx !== 1'b1) begin
         errors++;
         $display("FAIL stream_end got status=%h tx=%b want 4 1", rdata, tx);
      end
   endtask

   task automatic test_single();
      stim_q.delete();
      stim_q.push_back(8'h55);
      test_stream();
   endtask

   task automatic test_back_to_back();
      stim_q.delete();
      stim_q.push_back(8'hA1);
      stim_q.push_back(8'h3C);
      test_stream();
   endtask

   task automatic test_random();
      int n;
      repeat (4) begin
         stim_q.delete();
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom()));
         test_stream();
      end
   endtask

   task automatic test_overflow();
      logic [7:0] b [10];
      stim_q.delete();
      for (int i = 0; i < 10; i++) begin
         b[i] = 8'($urandom());
         if (i < 9) stim_q.push_back(b[i]);
      end
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               addr  = 32'h0000_1000;
               wdata = {24'h0, b[i]};
               we    = 1'b1;
            end
            @(negedge clk);
            we   = 1'b0;
            addr = 32'h0000_1004;
            #1;
            checks++;
            if (rdata !== 32'hB) begin
               errors++;
               $display("FAIL overflow_status got %h want b", rdata);
            end
            @(negedge clk);
            wdata = 32'h8;
            we    = 1'b1;
            @(negedge clk);
            we = 1'b0;
            #1;
            checks++;
            if (rdata !== 32'h3) begin
               errors++;
               $display("FAIL overflow_clear got %h want 3", rdata);
            end
         end
         begin
            repeat (2) @(negedge clk);
            for (int k = 0; k < FL * 9; k++) begin
               @(negedge clk);
               checks++;
               if (tx !== exp_line(k)) begin
                  errors++;
                  $display("FAIL overflow_tx k=%0d got %b want %b",
                           k, tx, exp_line(k));
               end
            end
         end
      join
      @(negedge clk);
      checks++;
      if (rdata !== 32'h4 || tx !== 1'b1) begin
         errors++;
         $display("FAIL overflow_end got status=%h tx=%b want 4 1", rdata, tx);
      end
   endtask

   task automatic test_reset_midframe();
      stim_q.delete();
      stim_q.push_back(8'h00);
      fork
         begin
            @(negedge clk);
            addr  = 32'h0000_1000;
            wdata = 32'h0;
            we    = 1'b1;
            @(negedge clk);
            we   = 1'b0;
            addr = 32'h0000_1004;
         end
         begin
            repeat (2) @(negedge clk);
            for (int k = 0; k <= 4 * C + 1; k++) begin
               @(negedge clk);
               checks++;
               if (tx !== exp_line(k)) begin
                  errors++;
                  $display("FAIL midreset_pre k=%0d got %b want %b",
                           k, tx, exp_line(k));
               end
            end
            rstn = 1'b0;
         end
      join
      @(negedge clk);
      rstn = 1'b1;
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL midreset_tx got %b want 1", tx);
      end
      checks++;
      if (rdata !== 32'h4) begin
         errors++;
         $display("FAIL midreset_status got %h want 4", rdata);
      end
      for (int k = 0; k < 2 * FL; k++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1 || rdata !== 32'h4) begin
            errors++;
            $display("FAIL midreset_quiet k=%0d got tx=%b status=%h want 1 4",
                     k, tx, rdata);
         end
      end
   endtask

   task automatic test_unmapped();
      @(negedge clk);
      addr  = 32'h0000_2000;
      wdata = $urandom();
      we    = 1'b1;
      #1;
      checks++;
      if (sel !== 1'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_2000 got sel=%b rdata=%h want 0 0", sel, rdata);
      end
      @(negedge clk);
      addr  = 32'h0000_2004;
      wdata = 32'hFF;
      #1;
      checks++;
      if (sel !== 1'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_2004 got sel=%b rdata=%h want 0 0", sel, rdata);
      end
      @(negedge clk);
      we   = 1'b0;
      addr = 32'h0000_1004;
      for (int k = 0; k < 3 * C; k++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1 || rdata !== 32'h4) begin
            errors++;
            $display("FAIL unmapped_quiet k=%0d got tx=%b status=%h want 1 4",
                     k, tx, rdata);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_random();
      test_overflow();
      test_reset_midframe();
      test_unmapped();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
